// File: rtl/stream_fork2_pkg.sv
// Shared definitions for the stream fork: default element width and FSM state encoding.
package stream_fork2_pkg;

  localparam int INT_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fork_state_e;

endpackage

// File: rtl/stream_fork2_fifo2.sv
// Small synchronous FIFO used once per fork branch; head reads as zero while empty.
module stream_fifo2 #(
  parameter int N     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [N-1:0] push_data,
  input  logic         pop,
  output logic [N-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage is left unreset; the empty gate on head hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_fork2.sv
// Two-way stream fork: every accepted element is copied into two independent branch FIFOs.
//
//  state | meaning
//  IDLE  | waiting for a start request, n latched on in_valid
//  RUN   | accepting elements until n taken and both branches drained
//  DONE  | run complete, holding out_valid until out_ready
module stream_fork2
  import stream_fork2_pkg::*;
#(
  parameter int N     = INT_N,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] n,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic [N-1:0] sIn,
  input  logic         sIn_valid,
  output logic         sIn_ready,
  output logic [N-1:0] sOutA,
  output logic         sOutA_valid,
  input  logic         sOutA_ready,
  output logic [N-1:0] sOutB,
  output logic         sOutB_valid,
  input  logic         sOutB_ready
);

  fork_state_e  state;
  logic [N-1:0] remaining;
  logic         full_a, full_b;
  logic         empty_a, empty_b;
  logic         push;

  // All handshake outputs decode registered state only.
  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign sIn_ready   = (state == RUN) && (remaining != '0) && !full_a && !full_b;
  assign push        = sIn_valid & sIn_ready;
  assign sOutA_valid = !empty_a;
  assign sOutB_valid = !empty_b;

  stream_fifo2 #(.N(N), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (sIn),
    .pop       (sOutA_ready),
    .head      (sOutA),
    .full      (full_a),
    .empty     (empty_a)
  );

  stream_fifo2 #(.N(N), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (sIn),
    .pop       (sOutB_ready),
    .head      (sOutB),
    .full      (full_b),
    .empty     (empty_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            remaining <= n;
            state     <= (n != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (push) begin
            remaining <= remaining - 1'b1;
          end
          if ((remaining == '0) && empty_a && empty_b) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
